// File: rtl/wb_row_sequencer_pkg.sv
// Shared layer code and FSM state encoding for the Layer1 writeback row sequencer.
package wb_row_sequencer_pkg;

    localparam logic [3:0] LAYER1 = 4'd1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_FLUSH = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/wb_row_sequencer.sv
// Row-by-row sequencer for the Layer1 writeback path: gates the PE groups, drives
// wb_en/FinishWB per row, counts rows and lends the BRAM32k port to readout when idle.
module wb_row_sequencer
    import wb_row_sequencer_pkg::*;
#(
    parameter int unsigned SUMS_PER_WORD = 8,
    parameter int unsigned WORDS_PER_ROW = 4,
    parameter int unsigned ROWS          = 28,
    parameter int unsigned FLUSH_CYC     = 2,
    parameter int unsigned CNT_W         = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] Layer,
    input  logic       rd_req,
    output logic       pe_go,
    output logic       wb_en,
    output logic       FinishWB,
    output logic       rd_gnt,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [4:0] row_idx
);

    localparam int unsigned SUM_LIMIT = WORDS_PER_ROW * SUMS_PER_WORD;
    localparam int unsigned FC_W      = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam int unsigned ROW_W     = 5;

    state_t           state;
    logic [CNT_W-1:0] sum_cnt;
    logic [FC_W-1:0]  flush_cnt;
    logic             aborting;

    // State and all outputs move together so every output is a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            sum_cnt   <= '0;
            flush_cnt <= '0;
            aborting  <= 1'b0;
            pe_go     <= 1'b0;
            wb_en     <= 1'b0;
            FinishWB  <= 1'b0;
            rd_gnt    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            row_idx   <= '0;
        end else begin
            done <= 1'b0;
            if (start && state != S_IDLE) begin
                err <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    rd_gnt <= rd_req;
                    // abort outranks start, even though it does nothing else here
                    if (start && !abort) begin
                        if (Layer == LAYER1) begin
                            state   <= S_RUN;
                            wb_en   <= 1'b1;
                            pe_go   <= 1'b0;
                            busy    <= 1'b1;
                            rd_gnt  <= 1'b0;
                            sum_cnt <= '0;
                            row_idx <= '0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end

                S_RUN: begin
                    if (abort) begin
                        state    <= S_GAP;
                        aborting <= 1'b1;
                        wb_en    <= 1'b0;
                        pe_go    <= 1'b0;
                    end else if (sum_cnt == CNT_W'(SUM_LIMIT)) begin
                        state     <= S_FLUSH;
                        wb_en     <= 1'b0;
                        pe_go     <= 1'b0;
                        FinishWB  <= 1'b1;
                        flush_cnt <= '0;
                    end else begin
                        sum_cnt <= sum_cnt + CNT_W'(1);
                        pe_go   <= 1'b1;
                    end
                end

                S_FLUSH: begin
                    if (abort || flush_cnt == FC_W'(FLUSH_CYC - 1)) begin
                        state    <= S_GAP;
                        FinishWB <= 1'b0;
                        aborting <= abort;
                    end else begin
                        flush_cnt <= flush_cnt + FC_W'(1);
                    end
                end

                // One quiet cycle lets the packer clear before the next row or exit.
                S_GAP: begin
                    if (aborting) begin
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                        row_idx  <= '0;
                        aborting <= 1'b0;
                    end else if (row_idx == ROW_W'(ROWS - 1)) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state   <= S_RUN;
                        row_idx <= row_idx + ROW_W'(1);
                        wb_en   <= 1'b1;
                        sum_cnt <= '0;
                    end
                end

                S_DONE: begin
                    state   <= S_IDLE;
                    busy    <= 1'b0;
                    row_idx <= '0;
                end

                default: begin
                    state    <= S_IDLE;
                    aborting <= 1'b0;
                    pe_go    <= 1'b0;
                    wb_en    <= 1'b0;
                    FinishWB <= 1'b0;
                    rd_gnt   <= 1'b0;
                    busy     <= 1'b0;
                    row_idx  <= '0;
                end
            endcase
        end
    end

endmodule
